// File: rtl/rvh_l1d_ptw_replay_queue.sv
// rvh_l1d_ptw_replay_queue
// Replay buffer for PTW walk requests that sits between the PTW and the L1D load pipe.
// Each walk ID has its own slot holding the walk paddr. When the STB flags a conflict,
// the slot waits a fixed delay and then re-issues the walk. Replays from several slots
// are round-robin arbitrated onto a single replay port. Once a grant is stalled, it is
// held until the handshake completes.
module rvh_l1d_ptw_replay_queue #(
  parameter int PTW_ID_WIDTH   = 2,
  parameter int PADDR_WIDTH    = 56,
  parameter int REPLAY_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ptw_walk_req_vld_i,
  input  logic [PTW_ID_WIDTH-1:0]   ptw_walk_req_id_i,
  input  logic [PADDR_WIDTH-1:0]    ptw_walk_req_addr_i,
  input  logic                      ptw_walk_resp_vld_i,
  input  logic                      ptw_walk_resp_rdy_i,
  input  logic [PTW_ID_WIDTH-1:0]   ptw_walk_resp_id_i,
  input  logic [2**PTW_ID_WIDTH-1:0] stb_l1d_ptw_replay_mask_i,
  output logic                      ptw_walk_replay_req_vld_o,
  output logic [PTW_ID_WIDTH-1:0]   ptw_walk_replay_req_id_o,
  output logic [PADDR_WIDTH-1:0]    ptw_walk_replay_req_paddr_o,
  input  logic                      ptw_walk_replay_req_rdy_i,
  output logic [2**PTW_ID_WIDTH-1:0] ptw_entry_vld_o
);

  localparam int ENTRY_NUM = 2 ** PTW_ID_WIDTH;
  localparam int CNT_WIDTH = (REPLAY_LATENCY > 2) ? $clog2(REPLAY_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(REPLAY_LATENCY - 1);

  logic [ENTRY_NUM-1:0]    valid_q;
  logic [ENTRY_NUM-1:0]    valid_d;
  logic [ENTRY_NUM-1:0]    pending_q;
  logic [ENTRY_NUM-1:0]    pending_d;
  logic [CNT_WIDTH-1:0]    cnt_q [ENTRY_NUM];
  logic [CNT_WIDTH-1:0]    cnt_d [ENTRY_NUM];
  logic [PADDR_WIDTH-1:0]  paddr_q [ENTRY_NUM];

  logic [PTW_ID_WIDTH-1:0] rr_ptr_q;
  logic [PTW_ID_WIDTH-1:0] rr_ptr_d;
  logic                    lock_vld_q;
  logic                    lock_vld_d;
  logic [PTW_ID_WIDTH-1:0] lock_id_q;
  logic [PTW_ID_WIDTH-1:0] lock_id_d;

  logic [ENTRY_NUM-1:0]    eligible;
  logic                    grant_vld;
  logic [PTW_ID_WIDTH-1:0] grant_id;
  logic [PTW_ID_WIDTH-1:0] search_idx;
  logic                    lock_kill;
  logic                    resp_fire;
  logic                    replay_fire;

  assign resp_fire   = ptw_walk_resp_vld_i & ptw_walk_resp_rdy_i;
  assign replay_fire = grant_vld & ptw_walk_replay_req_rdy_i;

  // A slot may replay once its delay counter has saturated while it is pending
  always_comb begin
    eligible = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      eligible[i] = valid_q[i] & pending_q[i] & (cnt_q[i] == CNT_MAX);
    end
  end

  // A held grant wins; otherwise search round-robin starting just after the last winner
  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    search_idx = '0;
    if (lock_vld_q) begin
      grant_vld = eligible[lock_id_q];
      grant_id  = lock_id_q;
    end else begin
      for (int k = 1; k <= ENTRY_NUM; k++) begin
        search_idx = rr_ptr_q + PTW_ID_WIDTH'(k);
        if (!grant_vld && eligible[search_idx]) begin
          grant_vld = 1'b1;
          grant_id  = search_idx;
        end
      end
    end
  end

  assign ptw_walk_replay_req_vld_o   = grant_vld;
  assign ptw_walk_replay_req_id_o    = grant_vld ? grant_id : '0;
  assign ptw_walk_replay_req_paddr_o = grant_vld ? paddr_q[grant_id] : '0;
  assign ptw_entry_vld_o             = valid_q;

  // Per-slot update in priority order: count, replay done, free, alloc, then STB re-arm
  always_comb begin
    valid_d   = valid_q;
    pending_d = pending_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (valid_q[i] && pending_q[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
      if (replay_fire && (grant_id == PTW_ID_WIDTH'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (resp_fire && (ptw_walk_resp_id_i == PTW_ID_WIDTH'(i))) begin
        valid_d[i]   = 1'b0;
        pending_d[i] = 1'b0;
      end
      if (ptw_walk_req_vld_i && (ptw_walk_req_id_i == PTW_ID_WIDTH'(i))) begin
        valid_d[i]   = 1'b1;
        pending_d[i] = 1'b0;
        cnt_d[i]     = '0;
      end
      if (stb_l1d_ptw_replay_mask_i[i] && valid_d[i]) begin
        pending_d[i] = 1'b1;
        cnt_d[i]     = '0;
      end
    end
  end

  // Hold a stalled grant unless its slot is freed, reallocated or re-armed this cycle
  always_comb begin
    lock_kill = (resp_fire && (ptw_walk_resp_id_i == grant_id)) ||
                (ptw_walk_req_vld_i && (ptw_walk_req_id_i == grant_id)) ||
                stb_l1d_ptw_replay_mask_i[grant_id];
    lock_vld_d = grant_vld & ~ptw_walk_replay_req_rdy_i & ~lock_kill;
    lock_id_d  = grant_vld ? grant_id : lock_id_q;
    rr_ptr_d   = replay_fire ? grant_id : rr_ptr_q;
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Walk paddr storage is written on allocation only and needs no reset
  always_ff @(posedge clk) begin
    if (ptw_walk_req_vld_i) begin
      paddr_q[ptw_walk_req_id_i] <= ptw_walk_req_addr_i;
    end
  end

  // Allocating a slot that is still live (and not being freed now) breaks the PTW protocol
  a_alloc_free_slot: assert property (@(posedge clk) disable iff (!rst)
    (ptw_walk_req_vld_i && !(resp_fire && (ptw_walk_resp_id_i == ptw_walk_req_id_i)))
      |-> !valid_q[ptw_walk_req_id_i]);

endmodule

// File: tb/tb_rvh_l1d_ptw_replay_queue.sv
// tb_rvh_l1d_ptw_replay_queue
// Directed bench with a scoreboard. Each stimulus pushes the replay it expects,
// together with the cycle it should appear in. A negedge monitor pops one entry and
// checks it on every replay handshake.
module tb_rvh_l1d_ptw_replay_queue;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic [1:0]  req_id;
  logic [55:0] req_addr;
  logic        resp_vld;
  logic        resp_rdy;
  logic [1:0]  resp_id;
  logic [3:0]  mask;
  logic        rep_rdy;
  logic        rep_vld;
  logic [1:0]  rep_id;
  logic [55:0] rep_paddr;
  logic [3:0]  entry_vld;

  typedef struct {
    logic [1:0]  id;
    logic [55:0] paddr;
    int          cycle;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   t0;

  localparam logic [55:0] RR_A0   = 56'h80_0000;
  localparam logic [55:0] RR_A1   = 56'h80_1040;
  localparam logic [55:0] RR_A2   = 56'h80_2080;
  localparam logic [55:0] RR_A3   = 56'h80_30C0;
  localparam logic [55:0] SGL_A1  = 56'h80_1000;
  localparam logic [55:0] FREE_A3 = 56'hFF_FFFF_FFFF_FFF8;
  localparam logic [55:0] LCK_A2  = 56'h12_3456_789A_BCD0;
  localparam logic [55:0] LCK_A0  = 56'h00_0000_0000_0040;

  rvh_l1d_ptw_replay_queue #(
    .PTW_ID_WIDTH   (2),
    .PADDR_WIDTH    (56),
    .REPLAY_LATENCY (4)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .ptw_walk_req_vld_i          (req_vld),
    .ptw_walk_req_id_i           (req_id),
    .ptw_walk_req_addr_i         (req_addr),
    .ptw_walk_resp_vld_i         (resp_vld),
    .ptw_walk_resp_rdy_i         (resp_rdy),
    .ptw_walk_resp_id_i          (resp_id),
    .stb_l1d_ptw_replay_mask_i   (mask),
    .ptw_walk_replay_req_vld_o   (rep_vld),
    .ptw_walk_replay_req_id_o    (rep_id),
    .ptw_walk_replay_req_paddr_o (rep_paddr),
    .ptw_walk_replay_req_rdy_i   (rep_rdy),
    .ptw_entry_vld_o             (entry_vld)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index shared by the stimulus and the monitor
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of pulses, then return them to idle
  task automatic applyStimulus(input logic a_req_vld, input logic [1:0] a_req_id,
                               input logic [55:0] a_req_addr, input logic a_resp_fire,
                               input logic [1:0] a_resp_id, input logic [3:0] a_mask);
    req_vld  = a_req_vld;
    req_id   = a_req_id;
    req_addr = a_req_addr;
    resp_vld = a_resp_fire;
    resp_rdy = a_resp_fire;
    resp_id  = a_resp_id;
    mask     = a_mask;
    tick();
    req_vld  = 1'b0;
    req_id   = 2'd0;
    req_addr = 56'd0;
    resp_vld = 1'b0;
    resp_rdy = 1'b0;
    resp_id  = 2'd0;
    mask     = 4'd0;
  endtask

  task automatic do_alloc(input logic [1:0] id, input logic [55:0] addr);
    applyStimulus(1'b1, id, addr, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic do_free(input logic [1:0] id);
    applyStimulus(1'b0, 2'd0, 56'd0, 1'b1, id, 4'd0);
  endtask

  task automatic do_mask(input logic [3:0] m);
    applyStimulus(1'b0, 2'd0, 56'd0, 1'b0, 2'd0, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 56'd0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [55:0] paddr, input int cycle);
    exp_t e;
    e.id    = id;
    e.paddr = paddr;
    e.cycle = cycle;
    exp_q.push_back(e);
  endtask

  // Monitor: every replay handshake must match the oldest expectation; idle outputs must be 0
  always @(negedge clk) begin
    if (rst) begin
      if (rep_vld) begin
        if (rep_rdy) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_replay_id", 64'(rep_id), 64'hFFFF);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("replay_id", 64'(rep_id), 64'(mon_e.id));
            checkOutput("replay_paddr", 64'(rep_paddr), 64'(mon_e.paddr));
            checkOutput("replay_cycle", 64'(cyc), 64'(mon_e.cycle));
          end
        end
      end else begin
        checkOutput("idle_id_zero", 64'(rep_id), 64'd0);
        checkOutput("idle_paddr_zero", 64'(rep_paddr), 64'd0);
      end
    end
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    req_vld  = 1'b1;
    req_id   = 2'd1;
    req_addr = 56'hAB_CDEF;
    resp_vld = 1'b1;
    resp_rdy = 1'b1;
    resp_id  = 2'd2;
    mask     = 4'hF;
    rep_rdy  = 1'b1;
    repeat (3) tick();
    checkOutput("reset_vld", 64'(rep_vld), 64'd0);
    checkOutput("reset_id", 64'(rep_id), 64'd0);
    checkOutput("reset_paddr", 64'(rep_paddr), 64'd0);
    checkOutput("reset_entry_vld", 64'(entry_vld), 64'd0);
    rst      = 1'b1;
    req_vld  = 1'b0;
    req_id   = 2'd0;
    req_addr = 56'd0;
    resp_vld = 1'b0;
    resp_rdy = 1'b0;
    resp_id  = 2'd0;
    mask     = 4'd0;
    idle(2);
    $display("[TB] round robin");
    do_alloc(2'd0, RR_A0);
    do_alloc(2'd1, RR_A1);
    do_alloc(2'd2, RR_A2);
    do_alloc(2'd3, RR_A3);
    checkOutput("rr_entry_full", 64'(entry_vld), 64'hF);
    t0 = cyc;
    push_exp(2'd1, RR_A1, t0 + 4);
    push_exp(2'd2, RR_A2, t0 + 5);
    push_exp(2'd3, RR_A3, t0 + 6);
    push_exp(2'd0, RR_A0, t0 + 7);
    do_mask(4'hF);
    idle(8);
    checkOutput("rr_drained_vld", 64'(rep_vld), 64'd0);
    for (int i = 0; i < 4; i++) do_free(2'(i));
    checkOutput("rr_all_freed", 64'(entry_vld), 64'd0);
    $display("[TB] single replay");
    t0 = cyc;
    push_exp(2'd1, SGL_A1, t0 + 4);
    applyStimulus(1'b1, 2'd1, SGL_A1, 1'b0, 2'd0, 4'b0010);
    idle(2);
    checkOutput("single_not_early", 64'(rep_vld), 64'd0);
    idle(1);
    checkOutput("single_vld", 64'(rep_vld), 64'd1);
    checkOutput("single_id", 64'(rep_id), 64'd1);
    idle(1);
    checkOutput("single_vld_drop", 64'(rep_vld), 64'd0);
    checkOutput("single_entry_held", 64'(entry_vld), 64'b0010);
    idle(2);
    checkOutput("single_entry_still", 64'(entry_vld), 64'b0010);
    do_free(2'd1);
    checkOutput("single_entry_freed", 64'(entry_vld), 64'd0);
    $display("[TB] free beats replay");
    do_alloc(2'd3, FREE_A3);
    t0 = cyc;
    push_exp(2'd3, FREE_A3, t0 + 4);
    do_mask(4'b1000);
    idle(3);
    checkOutput("free_vld_before", 64'(rep_vld), 64'd1);
    checkOutput("free_id_before", 64'(rep_id), 64'd3);
    do_free(2'd3);
    checkOutput("free_entry_cleared", 64'(entry_vld), 64'd0);
    checkOutput("free_vld_after", 64'(rep_vld), 64'd0);
    do_mask(4'b1000);
    idle(5);
    checkOutput("free_mask_ignored", 64'(rep_vld), 64'd0);
    checkOutput("free_entry_final", 64'(entry_vld), 64'd0);
    $display("[TB] grant lock");
    do_alloc(2'd2, LCK_A2);
    do_alloc(2'd0, LCK_A0);
    rep_rdy = 1'b0;
    t0 = cyc;
    do_mask(4'b0100);
    do_mask(4'b0001);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("lock_vld", 64'(rep_vld), 64'd1);
      checkOutput("lock_id", 64'(rep_id), 64'd2);
      checkOutput("lock_paddr", 64'(rep_paddr), 64'(LCK_A2));
      idle(1);
    end
    push_exp(2'd2, LCK_A2, t0 + 9);
    push_exp(2'd0, LCK_A0, t0 + 10);
    rep_rdy = 1'b1;
    idle(1);
    checkOutput("lock_next_id", 64'(rep_id), 64'd0);
    idle(3);
    checkOutput("lock_drained", 64'(rep_vld), 64'd0);
    $display("[TB] re-arm");
    t0 = cyc;
    push_exp(2'd0, LCK_A0, t0 + 6);
    do_mask(4'b0001);
    idle(1);
    do_mask(4'b0001);
    idle(1);
    checkOutput("rearm_not_t4", 64'(rep_vld), 64'd0);
    idle(1);
    checkOutput("rearm_not_t5", 64'(rep_vld), 64'd0);
    idle(1);
    checkOutput("rearm_vld_t6", 64'(rep_vld), 64'd1);
    idle(2);
    do_free(2'd0);
    do_free(2'd2);
    checkOutput("final_entry_vld", 64'(entry_vld), 64'd0);
    idle(4);
    checkOutput("missing_replay", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
